// File: rtl/zpu_mem_responder_if.sv
// Bus bundle between zpu_core (plus the UART sink) and zpu_mem_responder.
// Core side: one-cycle read/write strobes; mem_busy stalls the core.
// TX stream: a byte transfers on every rising edge where tx_valid and tx_ready
// are both high; tx_valid never depends on tx_ready, and tx_data is stable
// while tx_valid is high and no transfer has happened.
interface zpu_mem_responder_if;
  logic [27:0] mem_addr;
  logic        mem_readEnable;
  logic        mem_writeEnable;
  logic [31:0] mem_write;
  logic [3:0]  mem_writeMask;
  logic [31:0] mem_read;
  logic        mem_busy;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  // Environment side: the core drives the strobes, the UART sink drives tx_ready.
  modport master (
    output mem_addr, mem_readEnable, mem_writeEnable, mem_write, mem_writeMask,
    output tx_ready,
    input  mem_read, mem_busy, tx_data, tx_valid
  );

  // Responder side.
  modport slave (
    input  mem_addr, mem_readEnable, mem_writeEnable, mem_write, mem_writeMask,
    input  tx_ready,
    output mem_read, mem_busy, tx_data, tx_valid
  );
endinterface

// File: rtl/zpu_mem_responder.sv
// Memory-port responder for zpu_core: word RAM window, UART TX FIFO register,
// free-running cycle counter, registered busy stalls and a TX byte stream.
module zpu_mem_responder #(
  parameter int RAM_ADDR_W     = 12,
  parameter int READ_LAT       = 2,
  parameter int TXF_DEPTH_LOG2 = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  zpu_mem_responder_if.slave     bus,
  output logic [1:0]             fsm_state
);

  localparam int              DEPTH      = 1 << TXF_DEPTH_LOG2;
  localparam int              CW         = TXF_DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]   FULL_CNT   = CW'(DEPTH);
  localparam logic [3:0]      LAT_INIT   = 4'(READ_LAT - 1);
  localparam logic [11:0]     UART_OFF   = 12'h024;
  localparam logic [11:0]     CNT_OFF    = 12'h028;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_WSTALL = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [3:0]                lat_q, lat_d;
  logic [7:0]                stall_q, stall_d;
  logic                      busy_q;
  logic [31:0]               read_q;
  logic                      rd_is_io_q;
  logic [31:0]               io_rd_q;
  logic [31:0]               ram_rd_q;
  logic [31:0]               cnt_q;
  logic [TXF_DEPTH_LOG2-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]             count_q;

  logic [31:0]               ram [2**RAM_ADDR_W];
  logic [7:0]                fifo_mem [DEPTH];

  logic                      is_io;
  logic [11:0]               io_off;
  logic [RAM_ADDR_W-1:0]     ram_idx;
  logic                      fifo_full;
  logic                      pop;
  logic                      push;
  logic [7:0]                push_data;
  logic                      rd_take;
  logic                      rd_done;
  logic                      ram_we;
  logic [31:0]               io_rd_d;
  logic                      addr_unused;

  assign is_io       = bus.mem_addr[27];
  assign io_off      = bus.mem_addr[11:0];
  assign ram_idx     = bus.mem_addr[RAM_ADDR_W+1:2];
  assign addr_unused = ^bus.mem_addr;

  assign fifo_full    = (count_q == FULL_CNT);
  assign bus.tx_valid = (count_q != '0);
  assign bus.tx_data  = bus.tx_valid ? fifo_mem[rd_ptr_q] : 8'h00;
  assign pop          = bus.tx_valid & bus.tx_ready;

  assign bus.mem_busy = busy_q;
  assign bus.mem_read = read_q;
  assign fsm_state    = state_q;

  // IO read value, captured at the strobe edge so status/counter reflect that edge.
  always_comb begin
    io_rd_d = 32'h0;
    if (io_off == UART_OFF) begin
      io_rd_d = {23'h0, ~fifo_full, 8'h00};
    end else if (io_off == CNT_OFF) begin
      io_rd_d = cnt_q;
    end
  end

  // Next-state and strobe handling; strobes are only looked at in IDLE, write wins.
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    stall_d   = stall_q;
    push      = 1'b0;
    push_data = bus.mem_write[7:0];
    rd_take   = 1'b0;
    rd_done   = 1'b0;
    ram_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.mem_writeEnable) begin
          if (!is_io) begin
            ram_we = 1'b1;
          end else if (io_off == UART_OFF) begin
            if (!fifo_full) begin
              push = 1'b1;
            end else begin
              state_d = S_WSTALL;
              stall_d = bus.mem_write[7:0];
            end
          end
        end else if (bus.mem_readEnable) begin
          rd_take = 1'b1;
          state_d = S_READ;
          lat_d   = LAT_INIT;
        end
      end
      S_READ: begin
        if (lat_q == 4'd0) begin
          rd_done = 1'b1;
          state_d = S_IDLE;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      S_WSTALL: begin
        // The FIFO is full here, so a pop frees exactly the slot the held byte needs.
        if (pop) begin
          push      = 1'b1;
          push_data = stall_q;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, read path, counter and FIFO pointers; all cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      lat_q      <= 4'd0;
      stall_q    <= 8'h00;
      busy_q     <= 1'b0;
      read_q     <= 32'h0;
      rd_is_io_q <= 1'b0;
      io_rd_q    <= 32'h0;
      cnt_q      <= 32'h0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      stall_q <= stall_d;
      busy_q  <= (state_d != S_IDLE);
      cnt_q   <= cnt_q + 32'd1;
      if (rd_take) begin
        rd_is_io_q <= is_io;
        io_rd_q    <= io_rd_d;
      end
      if (rd_done) begin
        read_q <= rd_is_io_q ? io_rd_q : ram_rd_q;
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // RAM array: byte-lane writes and a synchronous read at the strobe edge.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_writeMask[b]) ram[ram_idx][8*b +: 8] <= bus.mem_write[8*b +: 8];
      end
    end
    if (rd_take) ram_rd_q <= ram[ram_idx];
  end

  // FIFO storage; validity is tracked by count_q so storage needs no reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: tb/tb_zpu_mem_responder.sv
// Bench for zpu_mem_responder: directed scenarios plus random traffic checked
// against a transaction-level model (word map, byte queue, busy countdown).
module tb_zpu_mem_responder;

  localparam int RAM_W    = 12;
  localparam int LAT      = 2;
  localparam int TXF_LOG2 = 2;
  localparam int TXF_DEP  = 1 << TXF_LOG2;

  logic       clk;
  logic       reset;
  logic [1:0] fsm_state;

  zpu_mem_responder_if bus_if ();

  zpu_mem_responder #(
    .RAM_ADDR_W     (RAM_W),
    .READ_LAT       (LAT),
    .TXF_DEPTH_LOG2 (TXF_LOG2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if),
    .fsm_state (fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_ram [int];
  logic [7:0]  exp_q [$];
  bit          m_stall;
  logic [7:0]  m_stall_byte;
  int          m_rd_left;
  logic [31:0] m_rd_val;
  logic [31:0] m_rdata;
  bit          m_busy;
  logic [31:0] m_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_stall   = 1'b0;
    m_rd_left = 0;
    m_rdata   = 32'h0;
    m_busy    = 1'b0;
    m_cyc     = 32'h0;
  endtask

  task automatic idle_inputs(input bit rdy);
    bus_if.mem_addr        = 28'h0;
    bus_if.mem_readEnable  = 1'b0;
    bus_if.mem_writeEnable = 1'b0;
    bus_if.mem_write       = 32'h0;
    bus_if.mem_writeMask   = 4'h0;
    bus_if.tx_ready        = rdy;
  endtask

  // One clock: check outputs against the model, drive inputs, advance the model.
  // Called and returns at a falling edge.
  task automatic step(input bit rd, input bit wr, input logic [27:0] addr,
                      input logic [31:0] data, input logic [3:0] mask, input bit rdy);
    bit          full;
    bit          popping;
    int          idx;
    logic [31:0] w;
    check("busy",     32'(bus_if.mem_busy), 32'(m_busy));
    check("tx_valid", 32'(bus_if.tx_valid), 32'(exp_q.size() != 0));
    check("tx_data",  32'(bus_if.tx_data),  (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
    check("mem_read", bus_if.mem_read,      m_rdata);
    bus_if.mem_addr        = addr;
    bus_if.mem_readEnable  = rd;
    bus_if.mem_writeEnable = wr;
    bus_if.mem_write       = data;
    bus_if.mem_writeMask   = mask;
    bus_if.tx_ready        = rdy;
    full    = (exp_q.size() == TXF_DEP);
    popping = (exp_q.size() != 0) && rdy;
    idx     = int'(addr[RAM_W+1:2]);
    if (popping) void'(exp_q.pop_front());
    if (m_stall) begin
      if (popping) begin
        exp_q.push_back(m_stall_byte);
        m_stall = 1'b0;
      end
    end else if (m_rd_left > 0) begin
      m_rd_left--;
      if (m_rd_left == 0) m_rdata = m_rd_val;
    end else if (wr) begin
      if (!addr[27]) begin
        w = m_ram.exists(idx) ? m_ram[idx] : 32'h0;
        for (int b = 0; b < 4; b++) if (mask[b]) w[8*b +: 8] = data[8*b +: 8];
        m_ram[idx] = w;
      end else if (addr[11:0] == 12'h024) begin
        if (!full) exp_q.push_back(data[7:0]);
        else begin
          m_stall      = 1'b1;
          m_stall_byte = data[7:0];
        end
      end
    end else if (rd) begin
      if (!addr[27])                   m_rd_val = m_ram.exists(idx) ? m_ram[idx] : 32'h0;
      else if (addr[11:0] == 12'h024)  m_rd_val = full ? 32'h0 : 32'h100;
      else if (addr[11:0] == 12'h028)  m_rd_val = m_cyc;
      else                             m_rd_val = 32'h0;
      m_rd_left = LAT;
    end
    m_busy = m_stall || (m_rd_left > 0);
    m_cyc  = m_cyc + 32'd1;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 28'h0, 32'h0, 4'h0, rdy);
  endtask

  task automatic bus_wr(input logic [27:0] a, input logic [31:0] d, input logic [3:0] m, input bit rdy);
    step(1'b0, 1'b1, a, d, m, rdy);
  endtask

  task automatic bus_rd(input logic [27:0] a, input bit rdy);
    step(1'b1, 1'b0, a, 32'h0, 4'h0, rdy);
    idle(LAT, rdy);
  endtask

  int          pool [16];
  logic [31:0] v1, v2;

  initial begin
    reset = 1'b0;
    idle_inputs(1'b0);
    model_reset();

    // Reset held for 3 cycles
    repeat (3) @(negedge clk);
    check("rst_busy",     32'(bus_if.mem_busy), 32'h0);
    check("rst_tx_valid", 32'(bus_if.tx_valid), 32'h0);
    check("rst_mem_read", bus_if.mem_read,      32'h0);
    check("rst_state",    32'(fsm_state),       32'h0);
    reset = 1'b1;
    model_reset();

    // Status read after reset: FIFO empty so not full
    bus_rd(28'h8000024, 1'b0);
    check("status_empty", bus_if.mem_read, 32'h00000100);

    // RAM byte lanes and aliasing
    bus_wr(28'h0000010, 32'hDEADBEEF, 4'hF, 1'b0);
    bus_wr(28'h0000010, 32'h00000055, 4'h1, 1'b0);
    bus_rd(28'h0000010, 1'b0);
    check("ram_lane", bus_if.mem_read, 32'hDEADBE55);
    bus_rd(28'h0004010, 1'b0);
    check("ram_alias", bus_if.mem_read, 32'hDEADBE55);

    // Read latency with a dropped second strobe
    bus_wr(28'h0000030, 32'h12345678, 4'hF, 1'b0);
    step(1'b1, 1'b0, 28'h0000030, 32'h0, 4'h0, 1'b0);
    check("lat_busy1", 32'(bus_if.mem_busy), 32'h1);
    step(1'b1, 1'b0, 28'h0000010, 32'h0, 4'h0, 1'b0);
    check("lat_busy2", 32'(bus_if.mem_busy), 32'h1);
    idle(1, 1'b0);
    check("lat_busy3", 32'(bus_if.mem_busy), 32'h0);
    check("lat_data",  bus_if.mem_read,      32'h12345678);
    idle(1, 1'b0);
    check("lat_busy4", 32'(bus_if.mem_busy), 32'h0);

    // FIFO fill, status, stall and release
    for (int i = 0; i < 4; i++) begin
      bus_wr(28'h8000024, 32'(8'h41 + i), 4'h0, 1'b0);
      check("fill_nostall", 32'(bus_if.mem_busy), 32'h0);
    end
    bus_rd(28'h8000024, 1'b0);
    check("status_full", bus_if.mem_read, 32'h0);
    bus_wr(28'h8000024, 32'h45, 4'hF, 1'b0);
    idle(3, 1'b0);
    check("stall_busy", 32'(bus_if.mem_busy), 32'h1);
    check("stall_head", 32'(bus_if.tx_data),  32'h41);
    idle(1, 1'b1);
    check("release_busy", 32'(bus_if.mem_busy), 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("drain", 32'(bus_if.tx_data), 32'(8'h42 + i));
      idle(1, 1'b1);
    end
    check("drained", 32'(bus_if.tx_valid), 32'h0);

    // Counter: strobes 10 cycles apart
    bus_rd(28'h8000028, 1'b0);
    v1 = bus_if.mem_read;
    idle(7, 1'b0);
    bus_rd(28'h8000028, 1'b0);
    v2 = bus_if.mem_read;
    check("cnt_diff", v2 - v1, 32'd10);

    // Both strobes: write wins, no read stall
    step(1'b1, 1'b1, 28'h0000020, 32'h7, 4'hF, 1'b0);
    check("coll_busy", 32'(bus_if.mem_busy), 32'h0);
    bus_rd(28'h0000020, 1'b0);
    check("coll_data", bus_if.mem_read, 32'h7);

    // Reset during WSTALL
    for (int i = 0; i < 4; i++) bus_wr(28'h8000024, 32'(8'h60 + i), 4'h0, 1'b0);
    bus_wr(28'h8000024, 32'h99, 4'h0, 1'b0);
    idle(2, 1'b0);
    check("pre_rst_busy", 32'(bus_if.mem_busy), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("async_busy",  32'(bus_if.mem_busy), 32'h0);
    check("async_valid", 32'(bus_if.tx_valid), 32'h0);
    idle_inputs(1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      idle(1, 1'b1);
      check("no_emit", 32'(bus_if.tx_valid), 32'h0);
    end

    // Random traffic
    for (int i = 0; i < 16; i++) begin
      pool[i] = 5 + i * 211;
      bus_wr({1'b0, 13'h0, 12'(pool[i]), 2'b00}, $urandom, 4'hF, 1'b0);
    end
    for (int i = 0; i < 600; i++) begin
      int          op;
      bit          rdy;
      logic [27:0] ra, ia;
      logic [11:0] off;
      op  = int'($urandom_range(0, 9));
      rdy = ($urandom_range(0, 2) == 0);
      ra  = {1'b0, 13'($urandom), 12'(pool[$urandom_range(0, 15)]), 2'($urandom)};
      case ($urandom_range(0, 3))
        0:       off = 12'h024;
        1:       off = 12'h028;
        2:       off = 12'h100;
        default: off = 12'h024;
      endcase
      ia = {1'b1, 15'($urandom), off};
      case (op)
        0, 1:    step(1'b0, 1'b1, ra, $urandom, 4'($urandom), rdy);
        2, 3:    step(1'b1, 1'b0, ra, 32'h0, 4'h0, rdy);
        4, 5:    step(1'b0, 1'b1, ia, $urandom, 4'($urandom), rdy);
        6:       step(1'b1, 1'b0, ia, 32'h0, 4'h0, rdy);
        7:       step(1'b1, 1'b1, ra, $urandom, 4'hF, rdy);
        default: step(1'b0, 1'b0, 28'h0, 32'h0, 4'h0, rdy);
      endcase
    end
    idle(12, 1'b1);
    check("final_empty", 32'(bus_if.tx_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
